// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry elastic pipeline register (main + skid) with a
// ready/valid handshake on each side, synchronous flush and a saturating
// counter of starved downstream cycles.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      upstream handshake; in_data, in_rd payload/tag
//   out_valid/out_ready    downstream handshake; out_data, out_rd payload/tag
//   flush                  drops every held word at the next edge
//   bubble_cnt             edges where out_ready=1 but nothing was offered
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0]       OCC_0   = 2'd0;
  localparam logic [1:0]       OCC_1   = 2'd1;
  localparam logic [1:0]       OCC_2   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        occ;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic              in_fire, out_fire;

  // Both handshake outputs come purely from occ, so there is no
  // out_ready -> in_ready path; the skid entry absorbs the extra word.
  assign in_ready  = (occ != OCC_2);
  assign out_valid = (occ != OCC_0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Bubble zeroing: rd 0 downstream means "no writeback".
  assign out_data = out_valid ? main_data : '0;
  assign out_rd   = out_valid ? main_rd   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= OCC_0;
      main_data <= '0;
      main_rd   <= '0;
      skid_data <= '0;
      skid_rd   <= '0;
    end else if (flush) begin
      // Flush wins over a same-cycle input transfer; that word is lost.
      occ       <= OCC_0;
      main_data <= '0;
      main_rd   <= '0;
      skid_data <= '0;
      skid_rd   <= '0;
    end else begin
      case (occ)
        OCC_0: begin
          if (in_fire) begin
            main_data <= in_data;
            main_rd   <= in_rd;
            occ       <= OCC_1;
          end
        end
        OCC_1: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
            main_rd   <= in_rd;
          end else if (in_fire) begin
            // main is held downstream, so the new word parks in skid
            skid_data <= in_data;
            skid_rd   <= in_rd;
            occ       <= OCC_2;
          end else if (out_fire) begin
            main_data <= '0;
            main_rd   <= '0;
            occ       <= OCC_0;
          end
        end
        OCC_2: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_rd   <= skid_rd;
            if (in_fire) begin
              // Not reachable (in_ready=0 here) but kept well defined.
              skid_data <= in_data;
              skid_rd   <= in_rd;
            end else begin
              skid_data <= '0;
              skid_rd   <= '0;
              occ       <= OCC_1;
            end
          end
        end
        default: begin
          occ       <= OCC_0;
          main_data <= '0;
          main_rd   <= '0;
          skid_data <= '0;
          skid_rd   <= '0;
        end
      endcase
    end
  end

  // Starvation counter: saturates, ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (out_ready && !out_valid && bubble_cnt != CNT_MAX)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0]   rd;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, flush;
  logic [DATA_W-1:0] in_data, out_data;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [CNT_W-1:0]  bubble_cnt;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    npop   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .flush(flush), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step: account for the transfers about to happen on this edge,
  // then advance one cycle and land 1ns after the edge.
  task automatic tick();
    logic  ifire, ofire;
    item_t e;
    ifire = in_valid && in_ready;
    ofire = out_valid && out_ready;
    if (ofire) begin
      if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_data", 64'(out_data), 64'(e.d));
        chk("sb_rd", 64'(out_rd), 64'(e.rd));
        npop++;
      end
    end
    if (flush) sb.delete();
    else if (ifire) sb.push_back('{d: in_data, rd: in_rd});
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
    in_valid = v; in_data = d; in_rd = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, latency 1 (bubble +1 on the first edge: ready, nothing offered)
    out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 5'd7);
    tick();
    drive(1'b0, '0, '0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hDEADBEEF);
    chk("single_rd", 64'(out_rd), 64'd7);
    tick();
    chk("single_after_valid", 64'(out_valid), 64'd0);
    chk("single_after_data", 64'(out_data), 64'd0);
    chk("single_after_rd", 64'(out_rd), 64'd0);
    out_ready = 1'b0;

    // Back-pressure into skid
    drive(1'b1, 32'd1, 5'd1);
    tick();
    chk("bp_ready_a", 64'(in_ready), 64'd1);
    chk("bp_data_a", 64'(out_data), 64'd1);
    drive(1'b1, 32'd2, 5'd2);
    tick();
    drive(1'b0, '0, '0);
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_hold_a", 64'(out_data), 64'd1);
    tick();
    chk("bp_still_a", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_then_b", 64'(out_data), 64'd2);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    chk("bubble_after_bp", 64'(bubble_cnt), 64'd1);

    // Streaming 100 words at one per cycle
    npop = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + 32'(i) * 3, 5'(i));
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ready", 64'(in_ready), 64'd1);
      if (i == 0) chk("stream_bubble_first", 64'(bubble_cnt), 64'd2);
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_count", 64'(npop), 64'd100);
    chk("stream_bubble_end", 64'(bubble_cnt), 64'd2);
    chk("stream_queue_empty", 64'(sb.size()), 64'd0);
    out_ready = 1'b0;

    // Flush at occupancy 2 with a word offered
    drive(1'b1, 32'hC, 5'd3); tick();
    drive(1'b1, 32'hD, 5'd4); tick();
    chk("fl2_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hE, 5'd5);
    flush = 1'b1;
    chk("fl2_valid_in_flush", 64'(out_valid), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_out_data", 64'(out_data), 64'd0);
    chk("fl2_out_rd", 64'(out_rd), 64'd0);
    chk("fl2_in_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    chk("fl2_never_out", 64'(out_valid), 64'd0);

    // Flush at occupancy 1: input transfer in the same cycle is discarded
    drive(1'b1, 32'hF, 5'd6); tick();
    drive(1'b1, 32'h1F, 5'd8);
    flush = 1'b1;
    chk("fl1_ready_in_flush", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl1_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl1_never_out", 64'(out_valid), 64'd0);
    chk("bubble_after_flush", 64'(bubble_cnt), 64'd2);

    // Async reset between edges at occupancy 2
    drive(1'b1, 32'hAA, 5'd9); tick();
    drive(1'b1, 32'hBB, 5'd10); tick();
    drive(1'b0, '0, '0);
    chk("ar_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out_data", 64'(out_data), 64'd0);
    chk("ar_out_rd", 64'(out_rd), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_bubble", 64'(bubble_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_after_valid", 64'(out_valid), 64'd0);

    // Bubble counter saturation with CNT_W=4
    out_ready = 1'b1;
    repeat (5) tick();
    chk("sat_5", 64'(bubble_cnt), 64'd5);
    repeat (15) tick();
    chk("sat_20", 64'(bubble_cnt), 64'd15);
    repeat (5) tick();
    chk("sat_hold", 64'(bubble_cnt), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the payload word (result/operand bundle).
REQ-002 SHALL have parameter RD_W, default 5, width of the destination-register tag.
REQ-003 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream word present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a word this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_rd, input, RD_W, upstream destination tag.
REQ-010 SHALL have port out_valid, output, 1, downstream word present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-012 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-013 SHALL have port out_rd, output, RD_W, downstream destination tag.
REQ-014 SHALL have port flush, input, 1, synchronous kill of all held words.
REQ-015 SHALL have port bubble_cnt, output, CNT_W, count of cycles downstream was ready but starved.

Function
REQ-016 SHALL hold up to two entries: main (drives outputs) and skid (overflow); occupancy 0, 1 or 2.
REQ-017 SHALL transfer in on in_valid && in_ready and out on out_valid && out_ready, both on the same edge.
REQ-018 SHALL drive in_ready = 1 when occupancy < 2, from registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = 1 when occupancy >= 1.
REQ-020 SHALL present an accepted word on out_* the cycle after acceptance when the stage was empty (latency 1).
REQ-021 SHALL sustain one word per cycle while out_ready stays high.
REQ-022 SHALL preserve order: skid contents move to main when main drains, and new input fills skid only when main is held.
REQ-023 SHALL, on simultaneous input and output transfer at occupancy 1, load main with the new word and keep occupancy 1.
REQ-024 SHALL, on simultaneous transfers at occupancy 2, move skid to main and the new word to skid. This case is unreachable because in_ready is 0 at occupancy 2; the block SHALL still define it.
REQ-025 SHALL force out_data = 0 and out_rd = 0 whenever out_valid = 0 (bubble zeroing, so rd 0 means no writeback).
REQ-026 SHALL, on flush = 1, set occupancy to 0 and zero both entries at the next edge; flush takes priority over a same-cycle input transfer, and that input word is discarded.
REQ-027 SHALL not gate in_ready or out_valid by flush in the flush cycle itself.
REQ-028 SHALL increment bubble_cnt on each edge where out_ready = 1 and out_valid = 0, saturating at 2^CNT_W-1 with no wrap.
REQ-029 SHALL leave bubble_cnt unaffected by flush.

Reset
REQ-030 SHALL, while rst_n = 0, immediately force occupancy 0, both entries 0, out_valid 0, out_data 0, out_rd 0, in_ready 1 and bubble_cnt 0, independent of clk.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.
REQ-032 SHALL, on reset asserted mid-transfer, discard all held words with no partial output.

Verification
REQ-033 SHALL be checked as follows: single word 0xDEADBEEF, rd 7, out_ready = 1 -> out_valid 1 with 0xDEADBEEF/7 exactly one cycle later, then out_valid 0 with out_data/out_rd 0.
REQ-034 SHALL be checked as follows: out_ready = 0 with words A = 1 and B = 2 sent back-to-back -> in_ready drops to 0 after B, out holds A; then out_ready = 1 -> A then B on consecutive cycles, in_ready 1 again.
REQ-035 SHALL be checked as follows: streaming 100 words with out_ready = 1 -> 100 outputs in order at 1 word/cycle, and bubble_cnt unchanged after the first word arrives.
REQ-036 SHALL be checked as follows: occupancy 2 plus flush = 1 together with in_valid = 1 -> next cycle out_valid 0, outputs 0, in_ready 1, and the flushed-cycle input is never output.
REQ-037 SHALL be checked as follows: CNT_W = 4 with idle input and out_ready = 1 for 20 cycles -> bubble_cnt reaches 15 and holds at 15.
REQ-038 SHALL be checked as follows: rst_n pulsed low between clock edges while occupancy is 2 -> outputs zero and in_ready 1 before the next edge, and bubble_cnt 0.
